// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps every input combination of a small combinational
// function block in ascending order, waits SETTLE cycles per combination,
// samples y_in and assembles the full truth table into table_out.
// Optional feature macro: SCAN_COMPARE_EN. When it is defined, the completed
// table is compared against EXPECTED and the result is held on mismatch.
// When it is undefined, mismatch is tied low.
module truth_table_scanner #(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned SETTLE = 2,
    parameter logic [(1 << N_INPUTS)-1:0] EXPECTED = 16'h15A8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       y_in,
    output logic [N_INPUTS-1:0]        abcd,
    output logic                       busy,
    output logic                       done,
    output logic [(1 << N_INPUTS)-1:0] table_out,
    output logic                       mismatch
);

    localparam int unsigned W = 1 << N_INPUTS;
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
    localparam logic [3:0] CntOne = 4'd1;
    localparam logic [N_INPUTS-1:0] LastIdx = '1;
    localparam logic [N_INPUTS-1:0] IdxOne = 1;

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    state_e              state_q, state_d;
    logic [N_INPUTS-1:0] index_q, index_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [W-1:0]        shadow_q, shadow_d;
    logic [W-1:0]        table_q, table_d;
    logic [N_INPUTS-1:0] abcd_q, abcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state logic; outputs are derived from the next state so every output is registered.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        table_d  = table_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StDrive;
                    index_d  = '0;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            StDrive: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == SettleLast) begin
                        state_d = StSample;
                    end
                end
            end
            StSample: begin
                // Abort wins over the capture on the same edge.
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    shadow_d[index_q] = y_in;
                    if (index_q == LastIdx) begin
                        state_d = StDone;
                        // Publish the table on DONE entry so it is visible alongside done.
                        table_d = shadow_d;
                    end else begin
                        index_d = index_q + IdxOne;
                        cnt_d   = '0;
                        state_d = StDrive;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StDrive) || (state_d == StSample);
        done_d = (state_d == StDone);
        abcd_d = busy_d ? index_d : '0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            index_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            table_q  <= '0;
            abcd_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            table_q  <= table_d;
            abcd_q   <= abcd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign abcd      = abcd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;

`ifdef SCAN_COMPARE_EN
    logic mismatch_q, mismatch_d;

    // Compare result is refreshed only on DONE entry and held otherwise.
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_d == StDone) begin
            mismatch_d = (shadow_d != EXPECTED);
        end
    end

    // Compare result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: stimulus pushes the expected table
// for every accepted scan, a negedge monitor pops and compares on each done.
module tb_truth_table_scanner;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned L      = 16 * (SETTLE + 1);
    localparam logic [15:0] LAB    = 16'h15A8;
`ifdef SCAN_COMPARE_EN
    localparam bit COMPARE = 1'b1;
`else
    localparam bit COMPARE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, start, abort, y_in;
    logic [3:0]  abcd;
    logic        busy, done, mismatch;
    logic [15:0] table_out;
    logic        start1, abort1, y_in1;
    logic [3:0]  abcd1;
    logic        busy1, done1, mismatch1;
    logic [15:0] table_out1;

    // Function block under scan: arbitrary 4-input truth table held by the bench.
    logic [15:0] func;
    assign y_in  = func[abcd];
    assign y_in1 = abcd1[0];

    always #5 clk = ~clk;

    truth_table_scanner #(.N_INPUTS(4), .SETTLE(SETTLE), .EXPECTED(LAB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .y_in(y_in),
        .abcd(abcd), .busy(busy), .done(done), .table_out(table_out), .mismatch(mismatch)
    );

    truth_table_scanner #(.N_INPUTS(4), .SETTLE(1), .EXPECTED(LAB)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1), .y_in(y_in1),
        .abcd(abcd1), .busy(busy1), .done(done1), .table_out(table_out1),
        .mismatch(mismatch1)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          done_stamps[$];
    int          done1_stamps[$];
    logic [15:0] last_table;
    int          busy_run;
    bit          expect_abort;
    logic        prev_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_mismatch(input logic [15:0] t);
        return COMPARE && (t != LAB);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: abcd sweep, busy length, done width, table hold and scoreboard pops.
    always @(negedge clk) begin
        logic [15:0] t;
        if (!reset_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                check("abcd_seq", 32'(abcd), 32'(busy_run / (SETTLE + 1)));
                busy_run++;
            end else begin
                if (busy_run != 0) begin
                    if (!expect_abort) begin
                        check("busy_len", 32'(busy_run), 32'(L));
                        check("done_after_busy", 32'(done), 32'd1);
                    end
                    expect_abort = 1'b0;
                    busy_run = 0;
                end
                check("abcd_idle", 32'(abcd), 32'd0);
            end
            if (done) begin
                check("done_width", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
                end else begin
                    t = exp_q.pop_front();
                    check("table_out", 32'(table_out), 32'(t));
                    check("mismatch", 32'(mismatch), 32'(exp_mismatch(t)));
                    last_table = t;
                end
                done_stamps.push_back(cyc);
            end else begin
                check("table_hold", 32'(table_out), 32'(last_table));
            end
            prev_done = done;
        end
    end

    // Records done pulses of the SETTLE=1 instance.
    always @(negedge clk) begin
        if (reset_n && done1) done1_stamps.push_back(cyc);
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scan_timeout: got %0d pending scans expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Caller is at a negedge with the scanner idle.
    task automatic run_scan(input logic [15:0] f);
        func = f;
        exp_q.push_back(f);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        func = '0; last_table = '0; expect_abort = 1'b0; busy_run = 0; prev_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_abcd", 32'(abcd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_scan(LAB);
        run_scan(16'hFFFF);
        run_scan(16'hAAAA);
        run_scan(16'hFFFF);

        // Abort at cycle 10 of a y_in=0 scan; a start pulse mid-scan is ignored.
        func = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        expect_abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_abcd", 32'(abcd), 32'd0);
        repeat (L + 5) @(negedge clk);
        check("abort_table", 32'(table_out), 32'hFFFF);
        check("abort_mismatch", 32'(mismatch), 32'(exp_mismatch(16'hFFFF)));

        // Asynchronous reset in the middle of a scan.
        func = LAB;
        exp_q.push_back(LAB);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_abcd", 32'(abcd), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_table", 32'(table_out), 32'd0);
        check("midrst_mismatch", 32'(mismatch), 32'd0);
        exp_q.delete();
        last_table = '0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        run_scan(LAB);

        for (int i = 0; i < 6; i++) begin
            run_scan(16'($urandom));
        end

        // start held 120 cycles: three scans accepted 50 apart (34 apart for SETTLE=1).
        func = 16'($urandom);
        done_stamps.delete();
        done1_stamps.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(func);
        start = 1'b1;
        start1 = 1'b1;
        repeat (120) @(negedge clk);
        start = 1'b0;
        start1 = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);
        check("held_dones", 32'(done_stamps.size()), 32'd3);
        for (int i = 1; i < done_stamps.size(); i++) begin
            check("held_period", 32'(done_stamps[i] - done_stamps[i-1]), 32'd50);
        end
        check("held1_dones", 32'(done1_stamps.size()), 32'd4);
        for (int i = 1; i < done1_stamps.size(); i++) begin
            check("held1_period", 32'(done1_stamps[i] - done1_stamps[i-1]), 32'd34);
        end
        check("held1_table", 32'(table_out1), 32'hAAAA);
        check("held1_mismatch", 32'(mismatch1), 32'(exp_mismatch(16'hAAAA)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
